csc_rgb2ycbcr: RTL

Parametrised, mode-selectable RGB-to-YCbCr colour-space converter for the video pixel pipeline. It sits directly after the RGB capture/demosaic stage and feeds the luma/chroma processing blocks. It generalises the fixed 8-bit BT.601 converter in several ways:
- configurable channel width;
- four run-time modes, latched at frame boundaries;
- saturation clamping with a saturation flag;
- optional round-to-nearest.

---
 rtl/csc_pkg.sv | 55 +++++
 rtl/csc_dot3.sv | 96 +++++++++
 rtl/csc_rgb2ycbcr.sv | 91 +++++++++
 3 files changed

// File: rtl/csc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csc_pkg
// Description : Mode encodings, coefficient table and per-mode offset/clamp
//               constants for the RGB-to-YCbCr converter (8-bit scale).
// Revision    : 1.0
// ============================================================================
package csc_pkg;

    localparam logic [1:0] c_mode_601f = 2'd0;
    localparam logic [1:0] c_mode_709f = 2'd1;
    localparam logic [1:0] c_mode_601s = 2'd2;
    localparam logic [1:0] c_mode_byp  = 2'd3;

    localparam int c_comp_y = 0;
    localparam int c_coef_w = 10;

    typedef logic signed [c_coef_w-1:0] coef_t;

    // [mode][component Y/Cb/Cr][channel R/G/B]; bypass is an exact identity at 1.0
    localparam coef_t c_coef_tab [4][3][3] = '{
        '{'{ 10'sd77,  10'sd150,  10'sd29}, '{-10'sd43, -10'sd85,  10'sd128}, '{10'sd128, -10'sd107, -10'sd21}},
        '{'{ 10'sd54,  10'sd183,  10'sd19}, '{-10'sd29, -10'sd99,  10'sd128}, '{10'sd128, -10'sd116, -10'sd12}},
        '{'{ 10'sd66,  10'sd129,  10'sd25}, '{-10'sd38, -10'sd74,  10'sd112}, '{10'sd112, -10'sd94,  -10'sd18}},
        '{'{ 10'sd256, 10'sd0,    10'sd0 }, '{ 10'sd0,   10'sd256, 10'sd0  }, '{10'sd0,    10'sd0,    10'sd256}}
    };

    function automatic int offset8(input logic [1:0] mode, input int comp);
        int v;
        v = 0;
        case (mode)
            c_mode_601f, c_mode_709f: v = (comp == c_comp_y) ? 0  : 128;
            c_mode_601s:              v = (comp == c_comp_y) ? 16 : 128;
            c_mode_byp:               v = 0;
            default:                  v = 0;
        endcase
        return v;
    endfunction

    function automatic int clamp_lo8(input logic [1:0] mode);
        return (mode == c_mode_601s) ? 16 : 0;
    endfunction

    // Full-range limit is all-ones at any width, so it is not a scaled 8-bit value
    function automatic int clamp_hi(input logic [1:0] mode, input int comp, input int ch_dw);
        int v;
        if (mode == c_mode_601s)
            v = ((comp == c_comp_y) ? 235 : 240) << (ch_dw - 8);
        else
            v = (1 << ch_dw) - 1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csc_dot3.sv
`default_nettype none
// ============================================================================
// Module      : csc_dot3
// Description : 4-stage signed dot product (multiply, sum+offset, shift,
//               clamp) for one output component. Rounding when CSC_ROUND_EN.
// Revision    : 1.0
// ============================================================================
module csc_dot3
    import csc_pkg::*;
#(
    parameter int CH_DW = 8,
    parameter int COMP  = 0
) (
    input  logic                 RGB_CLK,
    input  logic                 RESET,
    input  logic [1:0]           i_mode,
    input  logic                 i_load,
    input  logic [3*CH_DW-1:0]   i_rgb,
    input  coef_t                i_coef_r,
    input  coef_t                i_coef_g,
    input  coef_t                i_coef_b,
    output logic [CH_DW-1:0]     o_dat,
    output logic                 o_sat
);

    localparam int c_pw = CH_DW + 10;
    localparam int c_sw = CH_DW + 12;

    logic signed [c_pw-1:0] w_ch   [3];
    logic signed [c_pw-1:0] w_cf   [3];
    logic signed [c_pw-1:0] r_prod [3];
    logic signed [c_sw-1:0] r_sum;
    logic signed [c_sw-1:0] r_res;
    logic signed [c_sw-1:0] w_off;
    logic signed [c_sw-1:0] w_rnd;
    logic signed [c_sw-1:0] w_lo;
    logic signed [c_sw-1:0] w_hi;
    logic [1:0]             r_tag1, r_tag2, r_tag3;
    logic [CH_DW-1:0]       r_dat;
    logic                   r_sat;

    assign w_ch[0] = c_pw'(i_rgb[3*CH_DW-1 -: CH_DW]);
    assign w_ch[1] = c_pw'(i_rgb[2*CH_DW-1 -: CH_DW]);
    assign w_ch[2] = c_pw'(i_rgb[CH_DW-1:0]);
    assign w_cf[0] = c_pw'(i_coef_r);
    assign w_cf[1] = c_pw'(i_coef_g);
    assign w_cf[2] = c_pw'(i_coef_b);

    // Offset and limits follow the tag travelling with each pixel, not the live mode
    assign w_off = c_sw'(offset8(r_tag1, COMP)) <<< CH_DW;
    assign w_lo  = c_sw'(clamp_lo8(r_tag3) << (CH_DW - 8));
    assign w_hi  = c_sw'(clamp_hi(r_tag3, COMP, CH_DW));

`ifdef CSC_ROUND_EN
    assign w_rnd = r_sum + c_sw'(128);
`else
    assign w_rnd = r_sum;
`endif

    always_ff @(posedge RGB_CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 3; i++) r_prod[i] <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_tag3 <= '0;
            r_sum  <= '0;
            r_res  <= '0;
            r_dat  <= '0;
            r_sat  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) r_prod[i] <= w_ch[i] * w_cf[i];
            r_tag1 <= i_mode;
            r_sum  <= c_sw'(r_prod[0]) + c_sw'(r_prod[1]) + c_sw'(r_prod[2]) + w_off;
            r_tag2 <= r_tag1;
            r_res  <= w_rnd >>> 8;
            r_tag3 <= r_tag2;
            if (i_load) begin
                if (r_res < w_lo) begin
                    r_dat <= w_lo[CH_DW-1:0];
                    r_sat <= 1'b1;
                end else if (r_res > w_hi) begin
                    r_dat <= w_hi[CH_DW-1:0];
                    r_sat <= 1'b1;
                end else begin
                    r_dat <= r_res[CH_DW-1:0];
                    r_sat <= 1'b0;
                end
            end
        end
    end

    assign o_dat = r_dat;
    assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/csc_rgb2ycbcr.sv
`default_nettype none
// ============================================================================
// Module      : csc_rgb2ycbcr
// Description : Mode-selectable RGB-to-YCbCr converter, 4-cycle latency.
//               Optional round-to-nearest via macro CSC_ROUND_EN.
// Revision    : 1.0
// ============================================================================
module csc_rgb2ycbcr
    import csc_pkg::*;
#(
    parameter int         CH_DW     = 8,
    parameter logic [1:0] MODE_INIT = 2'd0
) (
    input  logic                 RGB_CLK,
    input  logic                 RESET,
    input  logic                 RGB_VSYNC,
    input  logic                 RGB_DVALID,
    input  logic [3*CH_DW-1:0]   RGB_DAT,
    input  logic [1:0]           MODE_SEL,
    output logic                 YCbCr_CLK,
    output logic                 YCbCr_VSYNC,
    output logic                 YCbCr_DVALID,
    output logic [CH_DW-1:0]     Y_DAT,
    output logic [CH_DW-1:0]     Cb_DAT,
    output logic [CH_DW-1:0]     Cr_DAT,
    output logic [1:0]           MODE_ACT,
    output logic                 SAT_FLAG
);

    logic             r_vsync_prev;
    logic [1:0]       r_mode_act;
    logic [3:0]       r_vs_dly;
    logic [3:0]       r_dv_dly;
    logic [2:0]       r_live;
    logic             w_vs_rise;
    logic [1:0]       w_mode_cur;
    logic [CH_DW-1:0] w_dat [3];
    logic [2:0]       w_sat;

    // The pixel sampled on the VSYNC rising edge already uses the new mode
    assign w_vs_rise  = RGB_VSYNC & ~r_vsync_prev;
    assign w_mode_cur = w_vs_rise ? MODE_SEL : r_mode_act;

    always_ff @(posedge RGB_CLK or negedge RESET) begin
        if (!RESET) begin
            r_vsync_prev <= 1'b0;
            r_mode_act   <= MODE_INIT;
            r_vs_dly     <= '0;
            r_dv_dly     <= '0;
            r_live       <= '0;
        end else begin
            r_vsync_prev <= RGB_VSYNC;
            r_mode_act   <= w_mode_cur;
            r_vs_dly     <= {r_vs_dly[2:0], RGB_VSYNC};
            r_dv_dly     <= {r_dv_dly[2:0], RGB_DVALID};
            r_live       <= {r_live[1:0], 1'b1};
        end
    end

    // r_live keeps output registers at zero until the first post-reset sample arrives
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comp
            csc_dot3 #(
                .CH_DW (CH_DW),
                .COMP  (gi)
            ) u_dot3 (
                .RGB_CLK  (RGB_CLK),
                .RESET    (RESET),
                .i_mode   (w_mode_cur),
                .i_load   (r_live[2]),
                .i_rgb    (RGB_DAT),
                .i_coef_r (c_coef_tab[w_mode_cur][gi][0]),
                .i_coef_g (c_coef_tab[w_mode_cur][gi][1]),
                .i_coef_b (c_coef_tab[w_mode_cur][gi][2]),
                .o_dat    (w_dat[gi]),
                .o_sat    (w_sat[gi])
            );
        end
    endgenerate

    assign YCbCr_CLK    = RGB_CLK;
    assign YCbCr_VSYNC  = r_vs_dly[3];
    assign YCbCr_DVALID = r_dv_dly[3];
    assign Y_DAT        = w_dat[0];
    assign Cb_DAT       = w_dat[1];
    assign Cr_DAT       = w_dat[2];
    assign MODE_ACT     = r_mode_act;
    assign SAT_FLAG     = (|w_sat) & r_dv_dly[3];

endmodule
`default_nettype wire
